// File: rtl/pc_pkg.sv
// Shared defaults and stack-op decode for the program-counter stage.
package pc_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int BUS_W           = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_CONFLICT
  } stack_op_e;

  // Push and pop together is reported as a conflict and neither is executed.
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_CONFLICT;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/bus bundle between the micro-coded control unit and pc_unit.
// Optional breakpoint signals exist only when PC_BREAKPOINT_EN is defined.
interface pc_unit_if import pc_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [BUS_W-1:0]  i_bus;
  logic [BUS_W-1:0]  o_bus;
  logic              o_busEn;
  logic              i_ctrlLoadPC;
  logic              i_ctrlIncrPC;
  logic              i_ctrlPCNOe;
  logic              i_ctrlPush;
  logic              i_ctrlPop;
  logic [ADDR_W-1:0] o_address;
  logic              o_stackFull;
  logic              o_stackEmpty;
  logic              o_stackErr;
  logic              o_break;
`ifdef PC_BREAKPOINT_EN
  logic [ADDR_W-1:0] i_bpAddr;
  logic              i_bpValid;
  logic              i_bpClear;
`endif

  // Control unit side
  modport master (
    output i_bus, i_ctrlLoadPC, i_ctrlIncrPC, i_ctrlPCNOe, i_ctrlPush, i_ctrlPop,
`ifdef PC_BREAKPOINT_EN
    output i_bpAddr, i_bpValid, i_bpClear,
`endif
    input  o_bus, o_busEn, o_address, o_stackFull, o_stackEmpty, o_stackErr, o_break
  );

  // PC unit side
  modport slave (
    input  i_bus, i_ctrlLoadPC, i_ctrlIncrPC, i_ctrlPCNOe, i_ctrlPush, i_ctrlPop,
`ifdef PC_BREAKPOINT_EN
    input  i_bpAddr, i_bpValid, i_bpClear,
`endif
    output o_bus, o_busEn, o_address, o_stackFull, o_stackEmpty, o_stackErr, o_break
  );

endinterface

// File: rtl/pc_stack.sv
// Return-address LIFO. Dropped operations (overflow, underflow, push+pop)
// leave pointer and contents untouched and raise a one-cycle err pulse.
module pc_stack import pc_pkg::*; #(
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int W     = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         pop_ok,
  output logic         err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_m1;
  logic [W-1:0]     mem_q [DEPTH];
  logic             push_ok;
  stack_op_e        op;

  // Decode operation, qualify against pointer state, compute next pointer
  always_comb begin
    op      = decode_op(push, pop);
    full    = (ptr_q == PTR_W'(DEPTH));
    empty   = (ptr_q == '0);
    push_ok = (op == OP_PUSH) && !full;
    pop_ok  = (op == OP_POP)  && !empty;
    err     = (op == OP_CONFLICT) || ((op == OP_PUSH) && full) || ((op == OP_POP) && empty);
    ptr_m1  = ptr_q - 1'b1;
    top     = mem_q[ptr_m1[IDX_W-1:0]];
    ptr_d   = ptr_q;
    if (push_ok)     ptr_d = ptr_q + 1'b1;
    else if (pop_ok) ptr_d = ptr_m1;
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[ptr_q[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, next-PC priority (pop > load > incr >
// hold), sticky stack error, bus drive and optional breakpoint.
// Optional feature macro: PC_BREAKPOINT_EN (adds breakpoint compare/latch).
// ADDR_W must not exceed the 8-bit bus width; upper bus bits are ignored.
module pc_unit import pc_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic       i_clk,
  input  logic       i_nReset,
  pc_unit_if.slave   pif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty, stk_pop_ok, stk_err;
  logic              err_q, err_d;
  logic [BUS_W-1:0]  bus_val;

  pc_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk    (i_clk),
    .rst_n  (i_nReset),
    .push   (pif.i_ctrlPush),
    .pop    (pif.i_ctrlPop),
    .din    (pc_q),
    .top    (stk_top),
    .full   (stk_full),
    .empty  (stk_empty),
    .pop_ok (stk_pop_ok),
    .err    (stk_err)
  );

  // Next PC: a pop that the stack rejected falls through to load/incr/hold
  always_comb begin
    pc_d = pc_q;
    if (stk_pop_ok)            pc_d = stk_top;
    else if (pif.i_ctrlLoadPC) pc_d = pif.i_bus[ADDR_W-1:0];
    else if (pif.i_ctrlIncrPC) pc_d = pc_q + ADDR_W'(1);
    err_d = err_q | stk_err;
  end

  // PC and sticky error registers
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  // Bus drive reflects the current (pre-update) PC
  always_comb begin
    bus_val              = '0;
    bus_val[ADDR_W-1:0]  = pc_q;
    pif.o_busEn          = ~pif.i_ctrlPCNOe;
    pif.o_bus            = pif.o_busEn ? bus_val : '0;
  end

  assign pif.o_address    = pc_q;
  assign pif.o_stackFull  = stk_full;
  assign pif.o_stackEmpty = stk_empty;
  assign pif.o_stackErr   = err_q;

`ifdef PC_BREAKPOINT_EN
  logic brk_q, brk_d;

  // Breakpoint latch: compares the registered PC, clear beats set
  always_comb begin
    brk_d = brk_q;
    if (pif.i_bpClear)                              brk_d = 1'b0;
    else if (pif.i_bpValid && (pc_q == pif.i_bpAddr)) brk_d = 1'b1;
  end

  // Breakpoint register
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) brk_q <= 1'b0;
    else           brk_q <= brk_d;
  end

  assign pif.o_break = brk_q;
`else
  assign pif.o_break = 1'b0;
`endif

endmodule
